// File: rtl/simon_kexp_ctrl.sv
// simon_kexp_ctrl: shares one simon_kexp key expander between two requesters with
// round-robin arbitration, a one-entry schedule cache and an expansion timeout.
module simon_kexp_ctrl #(
   parameter int unsigned SIMON_KEY_WIDTH = 128,
   parameter int unsigned TIMEOUT_CYCLES  = 256
) (
   input  logic                       ck,
   input  logic                       rst,
   input  logic [1:0]                 req_valid,
   input  logic [1:0]                 req_mode,
   input  logic [SIMON_KEY_WIDTH-1:0] req_key0,
   input  logic [SIMON_KEY_WIDTH-1:0] req_key1,
   output logic [1:0]                 req_ready,
   output logic [1:0]                 grant,
   input  logic [1:0]                 req_release,
   output logic                       err,
   output logic                       err_id,
   output logic                       kx_nrst,
   output logic                       kx_mode,
   output logic [SIMON_KEY_WIDTH-1:0] kx_key,
   output logic                       kx_valid,
   input  logic                       kx_ready,
   input  logic                       kx_exp_valid
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FLUSH  = 3'd1,
      LOAD   = 3'd2,
      EXPAND = 3'd3,
      OWNED  = 3'd4
   } state_t;

   state_t                     state_q, state_d;
   logic                       owner_q, owner_d;
   logic                       last_grant_q, last_grant_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       cache_valid_q, cache_valid_d;
   logic [SIMON_KEY_WIDTH-1:0] cached_key_q, cached_key_d;
   logic                       cached_mode_q, cached_mode_d;

   logic [1:0]                 req_ready_d;
   logic [1:0]                 grant_d;
   logic                       err_d;
   logic                       err_id_d;
   logic                       kx_nrst_d;
   logic                       kx_mode_d;
   logic [SIMON_KEY_WIDTH-1:0] kx_key_d;
   logic                       kx_valid_d;

   logic                       pick;
   logic [SIMON_KEY_WIDTH-1:0] pick_key;
   logic                       pick_mode;
   logic                       hit;
   logic                       timed_out;

   // Arbitration: a lone requester wins; on a tie the one not granted last time wins.
   always_comb begin
      pick      = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
      pick_key  = pick ? req_key1 : req_key0;
      pick_mode = req_mode[pick];
      hit       = cache_valid_q && (pick_key == cached_key_q) && (pick_mode == cached_mode_q);
      timed_out = (cnt_q == CNT_LAST);
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_grant_d  = last_grant_q;
      cnt_d         = cnt_q;
      cache_valid_d = cache_valid_q;
      cached_key_d  = cached_key_q;
      cached_mode_d = cached_mode_q;
      req_ready_d   = 2'b00;
      err_d         = 1'b0;
      err_id_d      = err_id;
      kx_mode_d     = kx_mode;
      kx_key_d      = kx_key;

      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               req_ready_d  = {pick, ~pick};
               kx_key_d     = pick_key;
               kx_mode_d    = pick_mode;
               owner_d      = pick;
               last_grant_d = pick;
               if (hit) begin
                  state_d = OWNED;
               end else begin
                  state_d       = FLUSH;
                  cache_valid_d = 1'b0;
               end
            end
         end
         FLUSH: begin
            state_d = LOAD;
            cnt_d   = '0;
         end
         LOAD: begin
            if (timed_out) begin
               state_d       = IDLE;
               err_d         = 1'b1;
               err_id_d      = owner_q;
               cache_valid_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (kx_valid && kx_ready) begin
                  state_d = EXPAND;
               end
            end
         end
         EXPAND: begin
            if (kx_exp_valid) begin
               state_d       = OWNED;
               cached_key_d  = kx_key;
               cached_mode_d = kx_mode;
               cache_valid_d = 1'b1;
            end else if (timed_out) begin
               state_d       = IDLE;
               err_d         = 1'b1;
               err_id_d      = owner_q;
               cache_valid_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         OWNED: begin
            if (req_release[owner_q]) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // State-derived outputs are registered from the next state so they line up with it.
      grant_d    = (state_d == OWNED) ? {owner_d, ~owner_d} : 2'b00;
      kx_valid_d = (state_d == LOAD);
      kx_nrst_d  = (state_d != FLUSH);
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         state_q       <= IDLE;
         owner_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         cnt_q         <= '0;
         cache_valid_q <= 1'b0;
         cached_key_q  <= '0;
         cached_mode_q <= 1'b0;
         req_ready     <= 2'b00;
         grant         <= 2'b00;
         err           <= 1'b0;
         err_id        <= 1'b0;
         kx_nrst       <= 1'b0;
         kx_mode       <= 1'b0;
         kx_key        <= '0;
         kx_valid      <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_grant_q  <= last_grant_d;
         cnt_q         <= cnt_d;
         cache_valid_q <= cache_valid_d;
         cached_key_q  <= cached_key_d;
         cached_mode_q <= cached_mode_d;
         req_ready     <= req_ready_d;
         grant         <= grant_d;
         err           <= err_d;
         err_id        <= err_id_d;
         kx_nrst       <= kx_nrst_d;
         kx_mode       <= kx_mode_d;
         kx_key        <= kx_key_d;
         kx_valid      <= kx_valid_d;
      end
   end

endmodule

// File: tb/tb_simon_kexp_ctrl.sv
// tb_simon_kexp_ctrl: randomized bench for simon_kexp_ctrl with a behavioural expander stub
// and a transaction-level model of arbitration, caching and timeout.
module tb_simon_kexp_ctrl;

   localparam int unsigned KW = 128;
   localparam int unsigned TO = 16;

   logic          ck = 1'b0;
   logic          rst;
   logic [1:0]    req_valid, req_mode, req_release;
   logic [KW-1:0] req_key0, req_key1;
   logic [1:0]    req_ready, grant;
   logic          err, err_id;
   logic          kx_nrst, kx_mode, kx_valid;
   logic [KW-1:0] kx_key;
   logic          kx_ready, kx_exp_valid;

   int n_tests = 0;
   int n_fail  = 0;

   int ld_dly, ex_dly;
   bit stub_hang;
   int stub_phase = 0;
   int stub_cnt   = 0;

   bit            m_cache_valid;
   logic [KW-1:0] m_key;
   logic          m_mode;
   int            m_last;

   simon_kexp_ctrl #(.SIMON_KEY_WIDTH(KW), .TIMEOUT_CYCLES(TO)) dut (
      .ck(ck), .rst(rst), .req_valid(req_valid), .req_mode(req_mode),
      .req_key0(req_key0), .req_key1(req_key1), .req_ready(req_ready), .grant(grant),
      .req_release(req_release), .err(err), .err_id(err_id), .kx_nrst(kx_nrst),
      .kx_mode(kx_mode), .kx_key(kx_key), .kx_valid(kx_valid), .kx_ready(kx_ready),
      .kx_exp_valid(kx_exp_valid)
   );

   always #5 ck = ~ck;

   // Expander stub: re-armed only by kx_nrst low, accepts after ld_dly, finishes after ex_dly.
   always @(negedge ck) begin
      kx_ready     = 1'b0;
      kx_exp_valid = 1'b0;
      if (kx_nrst !== 1'b1) begin
         stub_phase = 1;
         stub_cnt   = 0;
      end else begin
         case (stub_phase)
            1: if (kx_valid === 1'b1) begin
                  if (stub_cnt >= ld_dly) begin
                     kx_ready   = 1'b1;
                     stub_phase = 2;
                     stub_cnt   = 0;
                  end else stub_cnt++;
               end
            2: if (!stub_hang) begin
                  if (stub_cnt >= ex_dly) begin
                     kx_exp_valid = 1'b1;
                     stub_phase   = 3;
                  end else stub_cnt++;
               end
            default: ;
         endcase
      end
   end

   function automatic logic [KW-1:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      m_cache_valid = 1'b0;
      m_last        = 1;
   endtask

   // Raise req_valid[id]; follow whichever requester the model says wins until grant or err.
   task automatic acquire(input int id, input logic [KW-1:0] key, input logic mode,
                          input bit hang, output int w, output int waited, output bit granted);
      logic [1:0]    woh;
      logic [KW-1:0] wkey;
      logic          wmode;
      bit            hit, done;
      int            kv;
      if (id == 1) req_key1 = key; else req_key0 = key;
      req_mode[id]  = mode;
      req_valid[id] = 1'b1;
      ld_dly    = $urandom_range(0, 3);
      ex_dly    = $urandom_range(0, 8);
      stub_hang = hang;
      w       = (req_valid == 2'b11) ? 1 - m_last : (req_valid[1] ? 1 : 0);
      woh     = (w == 1) ? 2'b10 : 2'b01;
      wkey    = (w == 1) ? req_key1 : req_key0;
      wmode   = req_mode[w];
      granted = 1'b0;
      waited  = 0;
      do begin
         @(negedge ck);
         waited++;
      end while (req_ready == 2'b00 && waited < 20);
      req_valid[w] = 1'b0;
      n_tests++;
      if (req_ready !== woh) begin
         $display("FAIL accept_id: req_ready=%b required %b", req_ready, woh);
         n_fail++;
         return;
      end
      hit    = m_cache_valid && (wkey == m_key) && (wmode == m_mode);
      m_last = w;
      n_tests++;
      if (kx_key !== wkey || kx_mode !== wmode) begin
         $display("FAIL kx_capture: kx_key=%h kx_mode=%b required %h %b", kx_key, kx_mode, wkey, wmode);
         n_fail++;
      end
      if (hit) begin
         n_tests++;
         if (grant !== woh || kx_nrst !== 1'b1 || kx_valid !== 1'b0) begin
            $display("FAIL hit_grant: grant=%b kx_nrst=%b kx_valid=%b required %b 1 0",
                     grant, kx_nrst, kx_valid, woh);
            n_fail++;
         end
         granted = 1'b1;
         return;
      end
      m_cache_valid = 1'b0;
      n_tests++;
      if (kx_nrst !== 1'b0 || grant !== 2'b00) begin
         $display("FAIL flush: kx_nrst=%b grant=%b required 0 00", kx_nrst, grant);
         n_fail++;
      end
      kv   = 0;
      done = 1'b0;
      for (int k = 1; k <= 40 && !done; k++) begin
         @(negedge ck);
         if (kx_valid === 1'b1) kv++;
         if (hang) begin
            if (err !== 1'b0 || grant !== 2'b00) begin
               done = 1'b1;
               n_tests++;
               if (k != 1 + TO || err !== 1'b1 || err_id !== w[0] || grant !== 2'b00) begin
                  $display("FAIL timeout: cycle=%0d err=%b err_id=%b grant=%b required %0d 1 %0d 00",
                           k, err, err_id, grant, 1 + TO, w);
                  n_fail++;
               end
            end
         end else if (grant !== 2'b00 || err !== 1'b0) begin
            done = 1'b1;
            n_tests++;
            if (k != 3 + ld_dly + ex_dly || grant !== woh || err !== 1'b0 || kv != ld_dly + 1) begin
               $display("FAIL miss_grant: cycle=%0d grant=%b err=%b kx_valid_cycles=%0d required %0d %b 0 %0d",
                        k, grant, err, kv, 3 + ld_dly + ex_dly, woh, ld_dly + 1);
               n_fail++;
            end
            m_cache_valid = 1'b1;
            m_key         = wkey;
            m_mode        = wmode;
            granted       = 1'b1;
         end
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL no_response: no grant or err within 40 cycles");
      end
      if (hang) begin
         @(negedge ck);
         n_tests++;
         if (err !== 1'b0 || grant !== 2'b00) begin
            $display("FAIL err_pulse: err=%b grant=%b required 0 00", err, grant);
            n_fail++;
         end
      end
   endtask

   // Keep ownership for a while (with stray non-owner releases), then release.
   task automatic hold_release(input int w, input int hold);
      logic [1:0] woh;
      woh = (w == 1) ? 2'b10 : 2'b01;
      for (int i = 0; i < hold; i++) begin
         req_release[1-w] = 1'($urandom_range(0, 1));
         @(negedge ck);
         n_tests++;
         if (grant !== woh || kx_key !== m_key || kx_mode !== m_mode || kx_nrst !== 1'b1 ||
             kx_valid !== 1'b0 || req_ready !== 2'b00) begin
            $display("FAIL owned_hold: grant=%b kx_key=%h kx_valid=%b req_ready=%b required %b %h 0 00",
                     grant, kx_key, kx_valid, req_ready, woh, m_key);
            n_fail++;
         end
      end
      req_release = woh;
      @(negedge ck);
      req_release = 2'b00;
      n_tests++;
      if (grant !== 2'b00 || req_ready !== 2'b00) begin
         $display("FAIL release: grant=%b req_ready=%b required 00 00", grant, req_ready);
         n_fail++;
      end
   endtask

   task automatic test_reset();
      int w, wt; bit g;
      rst = 1'b1;
      req_valid = 2'b11;
      req_key0  = rand_key();
      req_key1  = rand_key();
      req_mode  = 2'b10;
      for (int i = 0; i < 3; i++) begin
         @(negedge ck);
         n_tests++;
         if (req_ready !== 2'b00 || grant !== 2'b00 || kx_nrst !== 1'b0 || err !== 1'b0 ||
             kx_valid !== 1'b0 || kx_key !== '0 || kx_mode !== 1'b0) begin
            $display("FAIL reset_state: req_ready=%b grant=%b kx_nrst=%b err=%b kx_valid=%b kx_mode=%b",
                     req_ready, grant, kx_nrst, err, kx_valid, kx_mode);
            n_fail++;
         end
      end
      rst = 1'b0;
      model_reset();
      acquire(0, req_key0, req_mode[0], 1'b0, w, wt, g);
      if (g) hold_release(w, 2);
      acquire(1, req_key1, req_mode[1], 1'b0, w, wt, g);
      if (g) hold_release(w, 1);
   endtask

   task automatic test_miss_expand();
      int w, wt; bit g;
      acquire(0, 128'h1b1a1918_13121110_0b0a0908_03020100, 1'b0, 1'b0, w, wt, g);
      if (g) hold_release(w, 3);
   endtask

   task automatic test_cache_hit();
      int w, wt; bit g;
      acquire(1, 128'h1b1a1918_13121110_0b0a0908_03020100, 1'b0, 1'b0, w, wt, g);
      if (g) hold_release(w, 2);
      acquire(1, 128'h1b1a1918_13121110_0b0a0908_03020101, 1'b0, 1'b0, w, wt, g);
      if (g) hold_release(w, 2);
   endtask

   task automatic test_back_to_back();
      int w, wt; bit g;
      for (int r = 0; r < 2; r++) begin
         req_key1      = rand_key();
         req_mode[1]   = 1'($urandom_range(0, 1));
         req_valid[1]  = 1'b1;
         acquire(0, rand_key(), 1'($urandom_range(0, 1)), 1'b0, w, wt, g);
         if (g) hold_release(w, 3);
         acquire(1, req_key1, req_mode[1], 1'b0, w, wt, g);
         n_tests++;
         if (wt != 1) begin
            $display("FAIL first_idle_accept: waited=%0d cycles required 1", wt);
            n_fail++;
         end
         if (g) hold_release(w, 1);
      end
   endtask

   task automatic test_timeout();
      int w, wt; bit g;
      logic [KW-1:0] k;
      k = rand_key();
      acquire(0, k, 1'b1, 1'b1, w, wt, g);
      acquire(0, k, 1'b1, 1'b0, w, wt, g);
      n_tests++;
      if (wt != 1) begin
         $display("FAIL idle_after_err: waited=%0d cycles required 1", wt);
         n_fail++;
      end
      if (g) hold_release(w, 1);
   endtask

   task automatic test_rst_midop();
      int w, wt; bit g;
      logic [KW-1:0] k;
      k = rand_key();
      req_key0 = k; req_mode[0] = 1'b0; req_valid[0] = 1'b1;
      ld_dly = 0; ex_dly = 8; stub_hang = 1'b0;
      wt = 0;
      do begin @(negedge ck); wt++; end while (req_ready == 2'b00 && wt < 20);
      req_valid[0] = 1'b0;
      repeat (4) @(negedge ck);
      for (int pass = 0; pass < 2; pass++) begin
         rst = 1'b1;
         @(negedge ck);
         rst = 1'b0;
         model_reset();
         n_tests++;
         if (grant !== 2'b00 || err !== 1'b0 || req_ready !== 2'b00 || kx_valid !== 1'b0 ||
             kx_nrst !== 1'b0 || kx_key !== '0) begin
            $display("FAIL rst_midop: grant=%b err=%b req_ready=%b kx_valid=%b kx_nrst=%b",
                     grant, err, req_ready, kx_valid, kx_nrst);
            n_fail++;
         end
         for (int i = 0; i < 12; i++) begin
            @(negedge ck);
            n_tests++;
            if (err !== 1'b0 || grant !== 2'b00) begin
               $display("FAIL rst_quiet: err=%b grant=%b required 0 00", err, grant);
               n_fail++;
            end
         end
         acquire(0, k, 1'b0, 1'b0, w, wt, g);
         if (pass == 0 && g) @(negedge ck);
      end
      if (g) hold_release(w, 1);
   endtask

   task automatic test_random();
      logic [KW-1:0] pool [3];
      int w, wt; bit g;
      for (int i = 0; i < 3; i++) pool[i] = rand_key();
      for (int t = 0; t < 24; t++) begin
         acquire($urandom_range(0, 1), pool[$urandom_range(0, 2)], 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), w, wt, g);
         if (g) hold_release(w, $urandom_range(0, 4));
         repeat ($urandom_range(0, 2)) @(negedge ck);
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 2'b00; req_mode = 2'b00; req_release = 2'b00;
      req_key0 = '0; req_key1 = '0;
      kx_ready = 1'b0; kx_exp_valid = 1'b0;
      ld_dly = 0; ex_dly = 0; stub_hang = 1'b0;
      model_reset();
      test_reset();
      test_miss_expand();
      test_cache_hit();
      test_back_to_back();
      test_timeout();
      test_rst_midop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

endmodule
